// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - state_t : debounce FSM states (IDLE, PRESS, HELD, RELEASE)
//   - cls_t   : classification of one full sweep snapshot
//   - KEY_*   : codes of the non-digit keys
//   - key_map : snapshot bit index (4*row + col) -> key code
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_EMPTY  = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for an asynchronous bus; flops reset to all ones
// (the idle level of pulled-up, active-low keypad rows).
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   d   - asynchronous input bus [DATA_W]
//   q   - synchronized output bus [DATA_W]
module sync_2ff #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      // stage 0: capture (may go metastable)
      meta_p0 <= d;
      // stage 1: resolved copy
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces whole-keypad snapshots and
// emits one-shot key events.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   row[3:0]  - keypad rows, active-low, asynchronous
//   col[3:0]  - keypad column drive, active-low one-hot
//   key_code  - code of the last accepted key (held until next accept)
//   key_valid - one-cycle strobe when a key is accepted
//   key_held  - high while the accepted key is still considered pressed
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter int          DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SLOT_W = (SCAN_DIV > 16'd1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 16'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]        row_sync;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic [15:0]       snap;
  logic              sweep_done;
  logic              slot_end;

  state_t            state, state_n;
  logic [3:0]        cand, cand_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept;

  logic [4:0]        ones;
  logic [3:0]        idx;
  cls_t              cls;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + 1'b1;
  endfunction

  sync_2ff #(.DATA_W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  assign col      = ~(4'b0001 << col_idx);
  assign slot_end = (slot_cnt == SLOT_LAST);

  // Each slot overwrites only its own column's four snapshot bits, so the
  // snapshot stays complete for a full slot after the sweep ends -- long
  // enough for the one-cycle classification that follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      col_idx    <= 2'd0;
      snap       <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= slot_end && (col_idx == 2'd3);
      if (slot_end) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        for (int r = 0; r < 4; r++) begin
          snap[{2'(r), col_idx}] <= ~row_sync[r];
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ones = 5'd0;
    idx  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end
    if (ones == 5'd0)      cls = CLS_EMPTY;
    else if (ones == 5'd1) cls = CLS_SINGLE;
    else                   cls = CLS_MULTI;
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (sweep_done) begin
      case (state)
        IDLE: begin
          if (cls == CLS_SINGLE) begin
            state_n = PRESS;
            cand_n  = idx;
            cnt_n   = CNT_W'(1);
          end
        end
        PRESS: begin
          if (cls == CLS_SINGLE && idx == cand) begin
            cnt_n = sat_inc(cnt);
          end else if (cls == CLS_SINGLE) begin
            cand_n = idx;
            cnt_n  = CNT_W'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        HELD: begin
          if (cls == CLS_EMPTY) begin
            state_n = RELEASE;
            cnt_n   = CNT_W'(1);
          end
        end
        default: begin
          if (cls == CLS_EMPTY) begin
            cnt_n = sat_inc(cnt);
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end
      endcase
      // Threshold checks after counting, so DEBOUNCE_SCANS=1 passes straight
      // through PRESS/RELEASE in the same sweep evaluation.
      if (state_n == PRESS && cnt_n >= CNT_MAX) begin
        state_n = HELD;
        cnt_n   = '0;
        accept  = 1'b1;
      end else if (state_n == RELEASE && cnt_n >= CNT_MAX) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_valid <= accept;
      key_held  <= (state_n == HELD) || (state_n == RELEASE);
      if (accept) key_code <= key_map(cand_n);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (one sweep = 16 cycles). A behavioural keypad pulls row[r] low while col[c]
// is low for every pressed (r,c). Cycle numbers below count from the first
// cycle after the last reset edge (cycle k ends at the k-th rising edge).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int base     = 0;
  int cyc_no   = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (16'd4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(pressed[4*r +: 4] & ~col);
    end
  end

  always @(posedge clk) begin
    if (rst) cyc_no <= 0;
    else     cyc_no <= cyc_no + 1;
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int m);
    while (cyc_no < m) @(negedge clk);
    #1;
  endtask

  task automatic restart(input logic [15:0] keys);
    @(negedge clk);
    #1;
    rst     = 1'b1;
    pressed = '0;
    repeat (2) @(negedge clk);
    #1;
    rst     = 1'b0;
    pressed = keys;
    base    = pulses;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_col"},   32'(col),       32'(4'b1110));
    chk({tag, "_code"},  32'(key_code),  32'(4'd0));
    chk({tag, "_valid"}, 32'(key_valid), 32'(1'b0));
    chk({tag, "_held"},  32'(key_held),  32'(1'b0));
  endtask

  initial begin
    // r1c1 (key 5) held for 10 sweeps, then released
    restart(16'h0020);
    check_reset("s1_rst");
    at(3);   chk("s1_col_c3",  32'(col), 32'(4'b1110));
    at(4);   chk("s1_col_c4",  32'(col), 32'(4'b1101));
    at(12);  chk("s1_col_c12", 32'(col), 32'(4'b0111));
    at(16);  chk("s1_col_c16", 32'(col), 32'(4'b1110));
    at(48);  chk("s1_valid_pre", 32'(key_valid), 32'(1'b0));
             chk("s1_held_pre",  32'(key_held),  32'(1'b0));
    at(49);  chk("s1_valid",     32'(key_valid), 32'(1'b1));
             chk("s1_code",      32'(key_code),  32'(4'd5));
             chk("s1_held",      32'(key_held),  32'(1'b1));
    at(50);  chk("s1_valid_post", 32'(key_valid), 32'(1'b0));
             chk("s1_held_post",  32'(key_held),  32'(1'b1));
    at(160); pressed = '0;
    at(208); chk("s1_held_rel_pre", 32'(key_held), 32'(1'b1));
    at(209); chk("s1_held_rel",     32'(key_held), 32'(1'b0));
             chk("s1_pulses",       32'(pulses - base), 32'(1));

    // r3c0 (*) for only 2 sweeps, then a full debounce from scratch
    restart(16'h1000);
    at(32);  pressed = '0;
    at(64);  chk("s2_pulses_short", 32'(pulses - base), 32'(0));
             chk("s2_held_short",   32'(key_held),      32'(1'b0));
             pressed = 16'h1000;
    at(81);  chk("s2_valid_early", 32'(key_valid), 32'(1'b0));
    at(112); chk("s2_valid_pre",   32'(key_valid), 32'(1'b0));
    at(113); chk("s2_valid",       32'(key_valid), 32'(1'b1));
             chk("s2_code",        32'(key_code),  32'(4'd14));

    // r0c3 (A) and r2c2 (9) together, then release r2c2
    restart(16'h0408);
    at(160); chk("s3_pulses_multi", 32'(pulses - base), 32'(0));
             chk("s3_held_multi",   32'(key_held),      32'(1'b0));
             pressed = 16'h0008;
    at(208); chk("s3_valid_pre", 32'(key_valid), 32'(1'b0));
    at(209); chk("s3_valid",     32'(key_valid), 32'(1'b1));
             chk("s3_code",      32'(key_code),  32'(4'd10));
             chk("s3_held",      32'(key_held),  32'(1'b1));

    // r3c2 (#) with a one-sweep bounce gap, then r3c1 (0)
    restart(16'h4000);
    at(49);  chk("s4_valid", 32'(key_valid), 32'(1'b1));
             chk("s4_code",  32'(key_code),  32'(4'd15));
    at(96);  pressed = '0;
    at(112); pressed = 16'h4000;
    at(130); chk("s4_held_bounce",   32'(key_held),      32'(1'b1));
             chk("s4_pulses_bounce", 32'(pulses - base), 32'(1));
    at(192); pressed = '0;
    at(240); chk("s4_held_rel_pre", 32'(key_held), 32'(1'b1));
    at(241); chk("s4_held_rel",     32'(key_held), 32'(1'b0));
    at(256); pressed = 16'h2000;
    at(304); chk("s4_code_keep", 32'(key_code),  32'(4'd15));
             chk("s4_valid0_pre", 32'(key_valid), 32'(1'b0));
    at(305); chk("s4_valid0",    32'(key_valid), 32'(1'b1));
             chk("s4_code0",     32'(key_code),  32'(4'd0));
    at(320); chk("s4_pulses",    32'(pulses - base), 32'(2));

    // r0c0 (1) with a one-cycle reset during the second debounce sweep
    restart(16'h0001);
    at(20);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst  = 1'b0;
    base = pulses;
    check_reset("s5_rst");
    at(48);  chk("s5_valid_pre", 32'(key_valid), 32'(1'b0));
    at(49);  chk("s5_valid",     32'(key_valid), 32'(1'b1));
             chk("s5_code",      32'(key_code),  32'(4'd1));
    at(60);  chk("s5_pulses",    32'(pulses - base), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
